// File: rtl/spill_mem_responder_pkg.sv
// Shared types for the misaligned-access DTIM responder: FSM states,
// request-type encodings and the response-data source selector.
package spill_mem_responder_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  localparam logic [1:0] RW_NOP     = 2'b00;
  localparam logic [1:0] RW_WRITE   = 2'b01;
  localparam logic [1:0] RW_READ    = 2'b10;
  localparam logic [1:0] RW_ILLEGAL = 2'b11;

  // Where RspData comes from in the response cycle.
  typedef enum logic [1:0] {
    RSP_ZERO  = 2'd0,
    RSP_LO    = 2'd1,
    RSP_SPILL = 2'd2
  } rsp_sel_e;

endpackage

// File: rtl/spill_mem_responder_if.sv
// LSU <-> DTIM request/response bundle. A request transfers when ReqValid and
// ReqReady are both high at a clock edge and ReqRW is not 00; RspValid is a one-cycle pulse with no back-pressure.
interface spill_mem_responder_if #(
  parameter int LLEN = 64,
  parameter int XLEN = 64
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic [1:0]            ReqRW;
  logic [XLEN-1:0]       ReqAdr;
  logic                  ReqSpill;
  logic [2*LLEN/8-1:0]   ReqByteMask;
  logic [2*LLEN-1:0]     ReqWriteData;
  logic                  RspValid;
  logic [2*LLEN-1:0]     RspData;
  logic                  RspErr;

  modport master (
    output ReqValid, ReqRW, ReqAdr, ReqSpill, ReqByteMask, ReqWriteData,
    input  ReqReady, RspValid, RspData, RspErr
  );

  modport slave (
    input  ReqValid, ReqRW, ReqAdr, ReqSpill, ReqByteMask, ReqWriteData,
    output ReqReady, RspValid, RspData, RspErr
  );
endinterface

// File: rtl/spill_mem_responder_ram1p.sv
// Single-port byte-enable SRAM, synchronous read-first with one-cycle latency.
// dout holds its value on cycles without ce.
module ram1p_be #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       bwe,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int i = 0; i < WIDTH/8; i++) begin
          if (bwe[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
      end
      dout <= mem[addr];
    end
  end
endmodule

// File: rtl/spill_mem_responder.sv
// DTIM responder for misaligned LSU accesses: a request spanning words W and
// W+1 is served over two beats of a single-port SRAM and returned as {W+1, W}.
module spill_mem_responder
  import spill_mem_responder_pkg::*;
#(
  parameter int LLEN  = 64,
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  spill_mem_responder_if.slave   bus,
  output state_e                 state_o
);
  localparam int BW  = LLEN / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int OFF = $clog2(BW);

  state_e           state_q, state_d;
  logic [AW-1:0]    w1_q, w1_d;
  logic [BW-1:0]    mask_hi_q, mask_hi_d;
  logic [LLEN-1:0]  data_hi_q, data_hi_d;
  logic [1:0]       rw_q, rw_d;
  logic [LLEN-1:0]  first_q, first_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  rsp_sel_e         rsp_sel_q, rsp_sel_d;

  logic             ram_ce, ram_we;
  logic [BW-1:0]    ram_bwe;
  logic [AW-1:0]    ram_addr;
  logic [LLEN-1:0]  ram_din, ram_dout;
  logic [AW-1:0]    word_idx;
  logic             accept;
  logic             adr_unused;

  assign word_idx   = bus.ReqAdr[AW+OFF-1:OFF];
  assign adr_unused = &{1'b0, bus.ReqAdr};
  assign accept     = bus.ReqValid & (state_q == ST_IDLE) & (bus.ReqRW != RW_NOP);

  always_comb begin
    state_d     = state_q;
    w1_d        = w1_q;
    mask_hi_d   = mask_hi_q;
    data_hi_d   = data_hi_q;
    rw_d        = rw_q;
    first_d     = first_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_sel_d   = RSP_ZERO;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_bwe     = '0;
    ram_addr    = word_idx;
    ram_din     = bus.ReqWriteData[LLEN-1:0];
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          w1_d      = word_idx + AW'(1);
          mask_hi_d = bus.ReqByteMask[2*BW-1:BW];
          data_hi_d = bus.ReqWriteData[2*LLEN-1:LLEN];
          rw_d      = bus.ReqRW;
          case (bus.ReqRW)
            RW_READ: begin
              ram_ce = 1'b1;
              if (bus.ReqSpill) state_d = ST_SECOND;
              else begin
                rsp_valid_d = 1'b1;
                rsp_sel_d   = RSP_LO;
              end
            end
            RW_WRITE: begin
              ram_ce  = 1'b1;
              ram_we  = 1'b1;
              ram_bwe = bus.ReqByteMask[BW-1:0];
              if (bus.ReqSpill) state_d = ST_SECOND;
              else rsp_valid_d = 1'b1;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_SECOND: begin
        state_d     = ST_IDLE;
        ram_ce      = 1'b1;
        ram_addr    = w1_q;
        rsp_valid_d = 1'b1;
        if (rw_q == RW_WRITE) begin
          ram_we  = 1'b1;
          ram_bwe = mask_hi_q;
          ram_din = data_hi_q;
        end else begin
          // dout now holds word W from the first beat.
          first_d   = ram_dout;
          rsp_sel_d = RSP_SPILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      w1_q        <= '0;
      mask_hi_q   <= '0;
      data_hi_q   <= '0;
      rw_q        <= RW_NOP;
      first_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_sel_q   <= RSP_ZERO;
    end else begin
      state_q     <= state_d;
      w1_q        <= w1_d;
      mask_hi_q   <= mask_hi_d;
      data_hi_q   <= data_hi_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_sel_q   <= rsp_sel_d;
    end
  end

  // Gating ce under reset abandons a pending second beat before it commits.
  ram1p_be #(.WIDTH(LLEN), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .ce   (ram_ce & ~reset),
    .we   (ram_we),
    .bwe  (ram_bwe),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_comb begin
    bus.RspData = '0;
    case (rsp_sel_q)
      RSP_LO:    bus.RspData = {{LLEN{1'b0}}, ram_dout};
      RSP_SPILL: bus.RspData = {ram_dout, first_q};
      default:   bus.RspData = '0;
    endcase
  end

  assign bus.ReqReady = (state_q == ST_IDLE);
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspErr   = rsp_err_q;
  assign state_o      = state_q;
endmodule

// File: doc/spill_mem_responder.md
Name: spill_mem_responder

Overview:
- Memory-side responder for the LSU's native misaligned-access path, implementing a tightly-coupled data memory (DTIM).
- Accepts one request that may span two LLEN words: 2*LLEN byte mask, 2*LLEN write data, and a spill flag.
- Services the request over one or two beats of a single-port LLEN-wide SRAM.
- Returns a 2*LLEN read word in the same layout the LSU merge/shift logic consumes: {upper word, lower word}.

Parameters:
- LLEN, 64, data word width in bits (32/64/128).
- XLEN, 64, address width.
- DEPTH, 1024, number of LLEN words in the SRAM (power of 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept this cycle
- ReqRW  in  2  10 read, 01 write, 11 illegal, 00 no-op (not accepted)
- ReqAdr  in  XLEN  byte address; word index W = ReqAdr[$clog2(DEPTH)+$clog2(LLEN/8)-1:$clog2(LLEN/8)]
- ReqSpill  in  1  access touches word W+1 as well
- ReqByteMask  in  2*LLEN/8  [LLEN/8-1:0] for word W, upper half for W+1
- ReqWriteData  in  2*LLEN  [LLEN-1:0] for word W, upper half for W+1
- RspValid  out  1  response valid (one-cycle pulse)
- RspData  out  2*LLEN  {word W+1, word W} on spill reads; {0, word W} on non-spill reads; 0 on writes
- RspErr  out  1  illegal ReqRW; qualified by RspValid

Behaviour:
- Accept = ReqValid & ReqReady & (ReqRW != 00).
- ReqReady = (state == IDLE).
- FSM states: IDLE, SECOND.
  - IDLE -> SECOND on accept with ReqSpill=1 and ReqRW in {10, 01}.
  - SECOND -> IDLE unconditionally after one cycle.
- Second-beat registers are captured on the accept cycle: W+1, upper mask, upper data, rw type.
- SRAM: single port, synchronous read with 1-cycle latency, byte-enable write that commits at the clock edge.
- Non-spill read accepted at cycle T:
  - SRAM read of W at T.
  - RspValid=1 at T+1 with RspData={0, mem[W]}.
  - Sustains one request per cycle.
- Spill read accepted at T:
  - Reads W at T and W+1 at T+1.
  - Word W is held in a first-half register.
  - RspValid at T+2 with {mem[W+1], mem[W]}.
  - ReqReady=0 at T+1.
- Write accepted at T:
  - Writes word W with lower mask at T.
  - For a spill, writes W+1 with upper mask at T+1.
  - RspValid at T+1 (non-spill) or T+2 (spill); RspData=0.
- Upper mask and data are ignored when ReqSpill=0.
- A zero lower or upper mask gives a no-write beat; timing is unchanged.
- Illegal 11 accepted at T: no SRAM access, RspValid=1 and RspErr=1 at T+1, RspData=0.
- Wrap-around: W+1 is computed modulo DEPTH, so a spill at word DEPTH-1 touches word 0.
- Read-after-write: a read accepted at T+1 following a write at T returns the new data. No bypass is needed because the write commits at T's edge.
- Reset values: state IDLE, RspValid 0, RspErr 0, RspData 0, first-half and second-beat registers 0. ReqReady is 1 from the first cycle after reset.
- Reset while in SECOND:
  - The second beat is abandoned and no response is issued.
  - A first-beat write has already committed.
- SRAM contents are not reset.

Decomposition:
- Shared package: responder state enum, ReqRW encodings (RW_READ=2'b10, RW_WRITE=2'b01, RW_ILLEGAL=2'b11).
- Sub-module ram1p_be: single-port byte-enable SRAM (params WIDTH, DEPTH); ports clk, ce, we, bwe, addr, din, dout. Synthesizes to block RAM.
- The top level holds the FSM, second-beat registers, first-half register and response registers.

Test Plan:
- Non-spill read: preload mem[5]=64'h1122334455667788; read ReqAdr=0x28 -> RspValid at T+1, RspData={64'h0, 64'h1122334455667788}, ReqReady stays 1.
- Spill read: mem[5]=64'hAAAA..., mem[6]=64'hBBBB...; read 0x2E with ReqSpill=1 -> ReqReady=0 at T+1, RspValid at T+2 with {BBBB..., AAAA...}.
- Spill write then read:
  - Write ReqAdr=0x2E, mask 16'h03C0, data low half bytes [7:6]=16'hCAFE, high half bytes [1:0]=16'hF00D.
  - Then read 0x28 with spill -> mem[5][63:48]=CAFE, mem[6][15:0]=F00D, other bytes unchanged.
- Wrap: spill read at word DEPTH-1 (ReqAdr=0x1FF8 for DEPTH=1024) -> upper half returns mem[0].
- Reset in SECOND:
  - Assert reset at T+1 of a spill write.
  - Word W written, word W+1 unchanged, no RspValid, ReqReady=1 after reset.
- Illegal and back-to-back:
  - ReqRW=11 -> RspValid, RspErr=1, RspData=0 at T+1.
  - Three back-to-back non-spill reads -> three consecutive RspValid pulses.
  - ReqRW=00 with ReqValid=1 -> no response.
